image_stream_axis_packer: RTL and testbench

- Downstream neighbour of the 3x3 mean-filter stage.
- Takes the filter's free-running valid/pixel stream, which has no backpressure, and tags each pixel with start-of-frame and end-of-line markers from the frame geometry.
- Buffers tagged pixels in a small first-word-fall-through FIFO and presents them as an AXI4-Stream video master (tuser = SOF, tlast = EOL) toward VDMA/display logic.
- Absorbs short downstream stalls and flags overflow when a stall outlasts the buffer.

---
 rtl/image_stream_axis_packer.sv | 96 +++++++++
 tb/tb_image_stream_axis_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/image_stream_axis_packer.sv
// Tags filter pixels with SOF/EOL from frame geometry and buffers them
// in a FWFT FIFO that drives an AXI4-Stream video master.
module image_stream_axis_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [10:0]                   img_width,
  input  logic [9:0]                    img_height,
  input  logic                          frame_start_i,
  input  logic                          valid_i,
  input  logic [DATA_W-1:0]             img_data_i,
  output logic [DATA_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + 2;

  logic [10:0]   x_cnt, cur_x, x_nxt;
  logic [9:0]    y_cnt, cur_y, y_nxt;
  logic          sof, eol;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, full;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;

  // frame_start_i overrides the counters for this cycle's tagging
  always_comb begin
    cur_x = frame_start_i ? 11'd0 : x_cnt;
    cur_y = frame_start_i ? 10'd0 : y_cnt;
    sof   = (cur_x == 11'd0) && (cur_y == 10'd0);
    eol   = (cur_x == img_width - 11'd1);
    x_nxt = cur_x;
    y_nxt = cur_y;
    if (valid_i) begin
      if (eol) begin
        x_nxt = 11'd0;
        y_nxt = (cur_y == img_height - 10'd1) ? 10'd0 : cur_y + 10'd1;
      end else begin
        x_nxt = cur_x + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
    end
  end

  assign full          = (level_o == LW'(FIFO_DEPTH));
  assign m_axis_tvalid = (level_o != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign push          = valid_i && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sof, eol, img_data_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase
      if (valid_i && !push) overflow_o <= 1'b1;
    end
  end

  // Gate the head so outputs read 0 whenever the FIFO is empty
  assign head         = mem[rd_ptr];
  assign m_axis_tdata = m_axis_tvalid ? head[DATA_W-1:0] : '0;
  assign m_axis_tuser = m_axis_tvalid & head[DATA_W+1];
  assign m_axis_tlast = m_axis_tvalid & head[DATA_W];

endmodule

// File: tb/tb_image_stream_axis_packer.sv
// Directed bench for image_stream_axis_packer.
// Drives W=4/H=2 frames and checks tagging, FIFO level and overflow.
module tb_image_stream_axis_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] img_width;
  logic [9:0]  img_height;
  logic        frame_start_i;
  logic        valid_i;
  logic [23:0] img_data_i;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [4:0]  level_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  image_stream_axis_packer #(.FIFO_DEPTH(16), .DATA_W(24)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .img_width     (img_width),
    .img_height    (img_height),
    .frame_start_i (frame_start_i),
    .valid_i       (valid_i),
    .img_data_i    (img_data_i),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .level_o       (level_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [23:0] d);
    valid_i    = 1'b1;
    img_data_i = d;
    tick();
    valid_i    = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    img_width     = 11'd4;
    img_height    = 10'd2;
    frame_start_i = 1'b0;
    valid_i       = 1'b0;
    img_data_i    = '0;
    m_axis_tready = 1'b1;
    reset_n       = 1'b0;
    tick();
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_level", 32'(level_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_tdata", 32'(m_axis_tdata), 0);
    chk("rst_tuser", 32'(m_axis_tuser), 0);
    chk("rst_tlast", 32'(m_axis_tlast), 0);
    reset_n = 1'b1;
    tick();

    // normal frame
    for (int i = 1; i <= 8; i++) begin
      pix(24'(i));
      chk("nrm_tvalid", 32'(m_axis_tvalid), 1);
      chk("nrm_tdata", 32'(m_axis_tdata), 32'(i));
      chk("nrm_tuser", 32'(m_axis_tuser), 32'(i == 1));
      chk("nrm_tlast", 32'(m_axis_tlast), 32'(i == 4 || i == 8));
      chk("nrm_level", 32'(level_o), 1);
    end
    tick();
    chk("nrm_empty", 32'(m_axis_tvalid), 0);
    chk("nrm_ovf", 32'(overflow_o), 0);

    // backpressure
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix(24'h10 + 24'(i));
      chk("bp_level", 32'(level_o), 32'(i + 1));
      chk("bp_hold_data", 32'(m_axis_tdata), 32'h10);
      chk("bp_hold_user", 32'(m_axis_tuser), 1);
    end
    m_axis_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("bp_drain_data", 32'(m_axis_tdata), 32'h10 + 32'(k));
      chk("bp_drain_user", 32'(m_axis_tuser), 32'(k % 8 == 0));
      chk("bp_drain_last", 32'(m_axis_tlast), 32'(k % 4 == 3));
      tick();
    end
    chk("bp_level_end", 32'(level_o), 0);
    chk("bp_ovf", 32'(overflow_o), 0);

    // overflow
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pix(24'h20 + 24'(i));
      if (i == 15) chk("ovf_pre", 32'(overflow_o), 0);
      if (i == 16) chk("ovf_set", 32'(overflow_o), 1);
    end
    chk("ovf_level", 32'(level_o), 16);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("ovf_drain_data", 32'(m_axis_tdata), 32'h20 + 32'(k));
      chk("ovf_drain_user", 32'(m_axis_tuser), 32'(k % 8 == 0));
      chk("ovf_drain_last", 32'(m_axis_tlast), 32'(k % 4 == 3));
      tick();
    end
    chk("ovf_empty", 32'(level_o), 0);
    for (int j = 0; j < 5; j++) begin
      pix(24'h40 + 24'(j));
      chk("ovf_geo_data", 32'(m_axis_tdata), 32'h40 + 32'(j));
      chk("ovf_geo_user", 32'(m_axis_tuser), 32'(j == 4));
      chk("ovf_geo_last", 32'(m_axis_tlast), 32'(j == 3));
    end
    chk("ovf_sticky", 32'(overflow_o), 1);
    tick();

    // full with simultaneous push and pop
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) pix(24'h50 + 24'(i));
    chk("full_level", 32'(level_o), 16);
    m_axis_tready = 1'b1;
    pix(24'h60);
    chk("full_pp_level", 32'(level_o), 16);
    chk("full_pp_ovf", 32'(overflow_o), 0);
    chk("full_pp_head", 32'(m_axis_tdata), 32'h51);
    for (int k = 0; k < 16; k++) begin
      chk("full_drain", 32'(m_axis_tdata),
          (k < 15) ? 32'h51 + 32'(k) : 32'h60);
      tick();
    end
    chk("full_empty", 32'(level_o), 0);

    // resync mid-frame at x=2, y=1
    do_reset();
    for (int i = 0; i < 6; i++) pix(24'h70 + 24'(i));
    frame_start_i = 1'b1;
    pix(24'h76);
    frame_start_i = 1'b0;
    chk("rs_user", 32'(m_axis_tuser), 1);
    chk("rs_last", 32'(m_axis_tlast), 0);
    pix(24'h77);
    chk("rs_p1_last", 32'(m_axis_tlast), 0);
    pix(24'h78);
    chk("rs_p2_last", 32'(m_axis_tlast), 0);
    pix(24'h79);
    chk("rs_p3_last", 32'(m_axis_tlast), 1);
    chk("rs_p3_user", 32'(m_axis_tuser), 0);
    tick();

    // async reset with level 5
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) pix(24'h80 + 24'(i));
    chk("ar_level_pre", 32'(level_o), 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_tvalid", 32'(m_axis_tvalid), 0);
    chk("ar_level", 32'(level_o), 0);
    chk("ar_ovf", 32'(overflow_o), 0);
    chk("ar_tdata", 32'(m_axis_tdata), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_axis_tready = 1'b1;
    pix(24'h88);
    chk("ar_sof_user", 32'(m_axis_tuser), 1);
    chk("ar_sof_data", 32'(m_axis_tdata), 32'h88);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
